// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU and its execute-stage wrapper.
//   alu_op_t    : operation code presented to the alu.
//   alu_flags_t : packed {zero, overflow, negative} flag bundle for a result.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational arithmetic/logic unit.
// Ports:
//   opcode   in  alu_op_t  operation select
//   in0      in  WIDTH     first operand
//   in1      in  WIDTH     second operand (shift amount is in1[4:0])
//   result   out WIDTH     operation result
//   zero     out 1         result == 0
//   overflow out 1         signed overflow of ADD/SUB, 0 for all other ops
//   negative out 1         result MSB
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t          opcode,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             negative
);

    logic signed [WIDTH-1:0] w_s0;
    logic signed [WIDTH-1:0] w_s1;
    logic        [WIDTH-1:0] w_sum;
    logic        [WIDTH-1:0] w_diff;
    logic        [4:0]       w_shamt;

    assign w_s0    = in0;
    assign w_s1    = in1;
    assign w_sum   = in0 + in1;
    assign w_diff  = in0 - in1;
    assign w_shamt = in1[4:0];

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (opcode)
            ALU_ADD: begin
                result   = w_sum;
                // Same-sign operands producing an opposite-sign sum.
                overflow = (in0[WIDTH-1] == in1[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != in0[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = w_diff;
                // Opposite-sign operands where the difference takes in1's sign.
                overflow = (in0[WIDTH-1] != in1[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != in0[WIDTH-1]);
            end
            ALU_AND:  result = in0 & in1;
            ALU_OR:   result = in0 | in1;
            ALU_XOR:  result = in0 ^ in1;
            ALU_SLL:  result = in0 << w_shamt;
            ALU_SRL:  result = in0 >> w_shamt;
            ALU_SRA:  result = w_s0 >>> w_shamt;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, (w_s0 < w_s1)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (in0 < in1)};
            default:  result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign negative = result[WIDTH-1];

endmodule

// File: rtl/alu_exec_stage.sv
// -----------------------------------------------------------------------------
// alu_exec_stage
// Two-stage valid/ready execute pipeline around the alu. S1 registers the
// operation and operands, the alu executes between S1 and S2, S2 registers the
// result and flags for writeback. Either operand may be replaced by the result
// of the previously executed op (in-order forwarding, no stall). A sticky
// overflow bit records any executed overflow until software clears it.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              upstream handshake
//   in_op, in_a, in_b              operation and operands
//   in_fwd_a, in_fwd_b             take operand from the previous result
//   out_valid/out_ready            downstream handshake
//   out_result                     registered alu result
//   out_zero/overflow/negative     registered flags of out_result
//   ovf_sticky, clr_sticky         sticky overflow status and its clear
// -----------------------------------------------------------------------------
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_fwd_a,
    input  logic             in_fwd_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_negative,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    // S1 operand register
    alu_op_t          r_op_p1;
    logic [WIDTH-1:0] r_a_p1;
    logic [WIDTH-1:0] r_b_p1;
    logic             r_fwd_a_p1;
    logic             r_fwd_b_p1;
    logic             r_vld_p1;

    // S2 output register
    logic [WIDTH-1:0] r_result_p2;
    alu_flags_t       r_flags_p2;
    logic             r_vld_p2;

    logic [WIDTH-1:0] r_last_result;
    logic             r_ovf_sticky;

    logic             w_s2_free;
    logic             w_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_in0;
    logic [WIDTH-1:0] w_in1;
    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_flags;

    assign w_s2_free = !r_vld_p2 || out_ready;
    assign w_adv     = r_vld_p1 && w_s2_free;
    // Depends only on state, out_ready and reset; never on in_valid.
    assign in_ready  = rst_n && (!r_vld_p1 || w_s2_free);
    assign w_accept  = in_valid && in_ready;

    // S1 control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1 <= 1'b1;
        end else if (w_adv) begin
            r_vld_p1 <= 1'b0;
        end
    end

    // S1 data: only consumed while r_vld_p1 is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_p1    <= in_op;
            r_a_p1     <= in_a;
            r_b_p1     <= in_b;
            r_fwd_a_p1 <= in_fwd_a;
            r_fwd_b_p1 <= in_fwd_b;
        end
    end

    // Execute: S1 -> alu -> S2
    assign w_in0 = r_fwd_a_p1 ? r_last_result : r_a_p1;
    assign w_in1 = r_fwd_b_p1 ? r_last_result : r_b_p1;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .opcode   (r_op_p1),
        .in0      (w_in0),
        .in1      (w_in1),
        .result   (w_result),
        .zero     (w_flags.zero),
        .overflow (w_flags.overflow),
        .negative (w_flags.negative)
    );

    // S2 register, forwarding source and sticky status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2      <= 1'b0;
            r_result_p2   <= '0;
            r_flags_p2    <= '0;
            r_last_result <= '0;
            r_ovf_sticky  <= 1'b0;
        end else begin
            if (w_adv) begin
                r_vld_p2      <= 1'b1;
                r_result_p2   <= w_result;
                r_flags_p2    <= w_flags;
                r_last_result <= w_result;
            end else if (out_ready) begin
                r_vld_p2 <= 1'b0;
            end

            // Set has priority over a same-cycle clear.
            if (w_adv && w_flags.overflow) begin
                r_ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_ovf_sticky <= 1'b0;
            end
        end
    end

    assign out_valid    = r_vld_p2;
    assign out_result   = r_result_p2;
    assign out_zero     = r_flags_p2.zero;
    assign out_overflow = r_flags_p2.overflow;
    assign out_negative = r_flags_p2.negative;
    assign ovf_sticky   = r_ovf_sticky;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    alu_op_t     in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_fwd_a;
    logic        in_fwd_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_negative;
    logic        ovf_sticky;
    logic        clr_sticky;

    int checks;
    int failures;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_fwd_a     (in_fwd_a),
        .in_fwd_b     (in_fwd_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_negative (out_negative),
        .ovf_sticky   (ovf_sticky),
        .clr_sticky   (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are then changed and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic fa, input logic fb);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_fwd_a = fa;
        in_fwd_b = fb;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_fwd_a = 1'b0;
        in_fwd_b = 1'b0;
    endtask

    // Flags packed as {zero, overflow, negative}.
    function automatic logic [31:0] flg();
        return {29'd0, out_zero, out_overflow, out_negative};
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = ALU_ADD;
        in_a       = '0;
        in_b       = '0;
        in_fwd_a   = 1'b0;
        in_fwd_b   = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;

        tick();
        tick();
        chk("rst_in_ready",   {31'd0, in_ready},   32'd0);
        chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
        chk("rst_out_result", out_result,          32'd0);
        chk("rst_flags",      flg(),               32'd0);
        chk("rst_sticky",     {31'd0, ovf_sticky}, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD 5+7
        issue(ALU_ADD, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        idle();
        chk("add_lat_vld0", {31'd0, out_valid}, 32'd0);
        tick();
        chk("add_vld",   {31'd0, out_valid}, 32'd1);
        chk("add_res",   out_result,         32'd12);
        chk("add_flags", flg(),              32'd0);
        tick();
        chk("add_drain", {31'd0, out_valid}, 32'd0);

        // Back-to-back forwarding: ADD 3+4, SUB last-10
        issue(ALU_ADD, 32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        issue(ALU_SUB, 32'h0000_0055, 32'd10, 1'b1, 1'b0);
        tick();
        idle();
        chk("fwd_add_res", out_result, 32'd7);
        tick();
        chk("fwd_sub_vld",   {31'd0, out_valid}, 32'd1);
        chk("fwd_sub_res",   out_result,         32'hFFFF_FFFD);
        chk("fwd_sub_flags", flg(),              32'b001);
        tick();

        // Overflow and sticky behaviour
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        chk("ovf_res",    out_result,          32'h8000_0000);
        chk("ovf_flags",  flg(),               32'b011);
        chk("ovf_sticky", {31'd0, ovf_sticky}, 32'd1);
        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
        tick();
        idle();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("ovf2_res",        out_result,          32'hFFFF_FFFE);
        chk("ovf2_flags",      flg(),               32'b011);
        chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("sticky_clear", {31'd0, ovf_sticky}, 32'd0);
        chk("pre_bp_empty", {31'd0, out_valid},  32'd0);

        // Backpressure: four ops, out_ready low for three edges
        out_ready = 1'b0;
        chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
        issue(ALU_ADD, 32'd1, 32'd1, 1'b0, 1'b0);
        tick();
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        issue(ALU_ADD, 32'd2, 32'd2, 1'b0, 1'b0);
        tick();
        chk("bp_rdy_drop", {31'd0, in_ready},  32'd0);
        chk("bp_out0",     out_result,         32'd2);
        issue(ALU_ADD, 32'd3, 32'd3, 1'b0, 1'b0);
        tick();
        chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
        chk("bp_hold_res", out_result,         32'd2);
        chk("bp_hold_rdy", {31'd0, in_ready},  32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", {31'd0, in_ready}, 32'd1);
        tick();
        issue(ALU_ADD, 32'd4, 32'd4, 1'b0, 1'b0);
        chk("bp_out1", out_result, 32'd4);
        tick();
        idle();
        chk("bp_out2", out_result, 32'd6);
        tick();
        chk("bp_out3",     out_result,         32'd8);
        chk("bp_out3_vld", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Zero flag and compares
        issue(ALU_SUB, 32'd9, 32'd9, 1'b0, 1'b0);
        tick();
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        chk("sub_zero_res",   out_result, 32'd0);
        chk("sub_zero_flags", flg(),      32'b100);
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        tick();
        idle();
        chk("slt_res", out_result, 32'd1);
        tick();
        chk("sltu_res",   out_result, 32'd0);
        chk("sltu_flags", flg(),      32'b100);
        tick();

        // Reset with both stages full
        out_ready = 1'b0;
        issue(ALU_ADD, 32'd10, 32'd10, 1'b0, 1'b0);
        tick();
        issue(ALU_ADD, 32'd20, 32'd20, 1'b0, 1'b0);
        tick();
        idle();
        chk("full_vld", {31'd0, out_valid}, 32'd1);
        chk("full_rdy", {31'd0, in_ready},  32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("async_rst_res", out_result,         32'd0);
        chk("async_rst_rdy", {31'd0, in_ready},  32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        issue(ALU_ADD, 32'hDEAD_BEEF, 32'd2, 1'b1, 1'b0);
        tick();
        idle();
        chk("post_rst_nodup", {31'd0, out_valid}, 32'd0);
        tick();
        chk("post_rst_fwd_vld", {31'd0, out_valid}, 32'd1);
        chk("post_rst_fwd_res", out_result,         32'd2);
        tick();
        chk("post_rst_drain", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
